// File: rtl/chan_ctrl_pkg.sv
// Shared types and default sizing for the channel fading run controller.
package chan_ctrl_pkg;

  localparam int unsigned ACC_W_DEF    = 10;
  localparam int unsigned PERIOD_W_DEF = 8;
  localparam int unsigned CNT_W_DEF    = 16;
  localparam int unsigned MIN_PERIOD   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SETTLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } chan_ctrl_state_e;

endpackage

// File: rtl/chan_fade_integrator.sv
// Saturating up/down fading integrator: climbs toward ceil on a 1 bit,
// decays toward 0 on a 0 bit, never wraps.
module chan_fade_integrator
  import chan_ctrl_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic             faster_clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             bit_i,
  input  logic [3:0]       up_step_i,
  input  logic [3:0]       dn_step_i,
  input  logic [ACC_W-1:0] ceil_i,
  output logic [ACC_W-1:0] level_o
);

  logic [ACC_W-1:0] level_q;
  logic [ACC_W-1:0] level_d;
  logic [ACC_W:0]   sum_c;

  // One extra bit on the sum so the ceiling compare sees true overflow.
  always_comb begin
    sum_c   = {1'b0, level_q} + (ACC_W+1)'(up_step_i);
    level_d = level_q;
    if (clear_i) begin
      level_d = '0;
    end else if (en_i) begin
      if (bit_i) begin
        level_d = (sum_c > {1'b0, ceil_i}) ? ceil_i : sum_c[ACC_W-1:0];
      end else begin
        level_d = (level_q > ACC_W'(dn_step_i)) ? level_q - ACC_W'(dn_step_i) : '0;
      end
    end
  end

  always_ff @(posedge faster_clk or negedge rst_n) begin
    if (!rst_n) level_q <= '0;
    else        level_q <= level_d;
  end

  assign level_o = level_q;

endmodule

// File: rtl/chan_fade_ctrl.sv
// Channel-emulation run controller: clear, settle, pull stimulus bits one UI
// at a time, drive the fading integrator and slice its level.
// Optional build macro CHAN_FADE_HYST_EN adds slicer hysteresis of +/-HYST.
module chan_fade_ctrl
  import chan_ctrl_pkg::*;
#(
  parameter int unsigned ACC_W    = ACC_W_DEF,
  parameter int unsigned PERIOD_W = PERIOD_W_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned HYST     = 8
) (
  input  logic                faster_clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [CNT_W-1:0]    cfg_nbits,
  input  logic [PERIOD_W-1:0] cfg_settle,
  input  logic [3:0]          cfg_up_step,
  input  logic [3:0]          cfg_dn_step,
  input  logic [ACC_W-1:0]    cfg_ceil,
  input  logic [ACC_W-1:0]    cfg_thresh,
  input  logic                bit_valid,
  input  logic                bit_data,
  output logic                bit_ready,
  output logic                busy,
  output logic                done,
  output logic                ui_strobe,
  output logic [ACC_W-1:0]    chan_level,
  output logic                chan_out,
  output logic                underrun
);

`ifdef CHAN_FADE_HYST_EN
  localparam int unsigned HystEff = HYST;
`else
  // Zero width collapses the band to a plain single-threshold slicer.
  localparam int unsigned HystEff = 0 * HYST;
`endif

  chan_ctrl_state_e    state_q;
  logic [PERIOD_W-1:0] period_q, ui_cnt_q, settle_cnt_q;
  logic [CNT_W-1:0]    bits_left_q;
  logic [3:0]          up_step_q, dn_step_q;
  logic [ACC_W-1:0]    ceil_q, thresh_q;
  logic                cur_bit_q, busy_q, done_q, ui_strobe_q, underrun_q, chan_out_q;

  logic [PERIOD_W-1:0] period_eff_c;
  logic                boundary_c, last_bit_c, bit_ready_c;
  logic [ACC_W:0]      thr_hi_sum_c;
  logic [ACC_W-1:0]    thr_hi_c, thr_lo_c;

  assign period_eff_c = (cfg_period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : cfg_period;
  assign boundary_c   = (state_q == ST_RUN) && (ui_cnt_q == '0);
  assign last_bit_c   = (bits_left_q == CNT_W'(1));
  assign bit_ready_c  = !abort && ((state_q == ST_LOAD) || (boundary_c && !last_bit_c));

  // Run sequencer; abort overrides every other transition.
  always_ff @(posedge faster_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      period_q     <= '0;
      ui_cnt_q     <= '0;
      settle_cnt_q <= '0;
      bits_left_q  <= '0;
      up_step_q    <= '0;
      dn_step_q    <= '0;
      ceil_q       <= '0;
      thresh_q     <= '0;
      cur_bit_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ui_strobe_q  <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      ui_strobe_q <= 1'b0;
      if (abort && (state_q != ST_IDLE)) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start) begin
              period_q     <= period_eff_c;
              settle_cnt_q <= cfg_settle;
              bits_left_q  <= cfg_nbits;
              up_step_q    <= cfg_up_step;
              dn_step_q    <= cfg_dn_step;
              ceil_q       <= cfg_ceil;
              thresh_q     <= cfg_thresh;
              underrun_q   <= 1'b0;
              busy_q       <= 1'b1;
              if (cfg_nbits == '0) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_CLEAR;
              end
            end
          end
          ST_CLEAR: state_q <= (settle_cnt_q == '0) ? ST_LOAD : ST_SETTLE;
          ST_SETTLE: begin
            settle_cnt_q <= settle_cnt_q - PERIOD_W'(1);
            if (settle_cnt_q == PERIOD_W'(1)) state_q <= ST_LOAD;
          end
          ST_LOAD: begin
            if (bit_valid) begin
              cur_bit_q <= bit_data;
              ui_cnt_q  <= period_q - PERIOD_W'(1);
              state_q   <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (ui_cnt_q == '0) begin
              bits_left_q <= bits_left_q - CNT_W'(1);
              ui_cnt_q    <= period_q - PERIOD_W'(1);
              if (last_bit_c) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else if (bit_valid) begin
                cur_bit_q <= bit_data;
              end else begin
                underrun_q <= 1'b1;
              end
            end else begin
              ui_cnt_q <= ui_cnt_q - PERIOD_W'(1);
              if (ui_cnt_q == PERIOD_W'(1)) ui_strobe_q <= 1'b1;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  chan_fade_integrator #(.ACC_W(ACC_W)) u_integrator (
    .faster_clk (faster_clk),
    .rst_n      (rst_n),
    .clear_i    (state_q == ST_CLEAR),
    .en_i       ((state_q == ST_RUN) && !abort),
    .bit_i      (cur_bit_q),
    .up_step_i  (up_step_q),
    .dn_step_i  (dn_step_q),
    .ceil_i     (ceil_q),
    .level_o    (chan_level)
  );

  // Slicer band edges, saturated at both ends of the level range.
  assign thr_hi_sum_c = {1'b0, thresh_q} + (ACC_W+1)'(HystEff);
  assign thr_hi_c     = thr_hi_sum_c[ACC_W] ? '1 : thr_hi_sum_c[ACC_W-1:0];
  assign thr_lo_c     = (thresh_q > ACC_W'(HystEff)) ? thresh_q - ACC_W'(HystEff) : '0;

  always_ff @(posedge faster_clk or negedge rst_n) begin
    if (!rst_n) begin
      chan_out_q <= 1'b0;
    end else if (state_q == ST_CLEAR) begin
      chan_out_q <= 1'b0;
    end else if (state_q != ST_IDLE) begin
      if (chan_level >= thr_hi_c)     chan_out_q <= 1'b1;
      else if (chan_level < thr_lo_c) chan_out_q <= 1'b0;
    end
  end

  assign bit_ready = bit_ready_c;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ui_strobe = ui_strobe_q;
  assign chan_out  = chan_out_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_chan_fade_ctrl.sv
// Directed self-checking bench for chan_fade_ctrl.
module tb_chan_fade_ctrl;

  logic       faster_clk = 1'b0;
  logic       rst_n, start, abort;
  logic [7:0] cfg_period, cfg_settle;
  logic [15:0] cfg_nbits;
  logic [3:0] cfg_up_step, cfg_dn_step;
  logic [9:0] cfg_ceil, cfg_thresh;
  logic       bit_valid, bit_data;
  logic       bit_ready, busy, done, ui_strobe, chan_out, underrun;
  logic [9:0] chan_level;

  int vec_cnt = 0;
  int err_cnt = 0;

  chan_fade_ctrl dut (
    .faster_clk (faster_clk), .rst_n (rst_n), .start (start), .abort (abort),
    .cfg_period (cfg_period), .cfg_nbits (cfg_nbits), .cfg_settle (cfg_settle),
    .cfg_up_step (cfg_up_step), .cfg_dn_step (cfg_dn_step), .cfg_ceil (cfg_ceil),
    .cfg_thresh (cfg_thresh), .bit_valid (bit_valid), .bit_data (bit_data),
    .bit_ready (bit_ready), .busy (busy), .done (done), .ui_strobe (ui_strobe),
    .chan_level (chan_level), .chan_out (chan_out), .underrun (underrun)
  );

  always #5 faster_clk = ~faster_clk;

  task automatic tick();
    @(posedge faster_clk);
    #1;
  endtask

  task automatic set_cfg(input int per, input int nb, input int st, input int up,
                         input int dn, input int ceil_v, input int thr);
    cfg_period  = 8'(per);
    cfg_nbits   = 16'(nb);
    cfg_settle  = 8'(st);
    cfg_up_step = 4'(up);
    cfg_dn_step = 4'(dn);
    cfg_ceil    = 10'(ceil_v);
    cfg_thresh  = 10'(thr);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    vec_cnt++;
    if ({busy, done, ui_strobe, chan_out, underrun, bit_ready} !== 6'b0) begin
      err_cnt++;
      $display("FAIL reset_flags: got %b want 000000", {busy, done, ui_strobe, chan_out, underrun, bit_ready});
    end
    vec_cnt++;
    if (chan_level !== 10'd0) begin
      err_cnt++; $display("FAIL reset_level: got %0d want 0", chan_level);
    end
    @(negedge faster_clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int strobes = 0, dones = 0, t_lvl2 = -1, t_out = -1, t_last = -1, t_done = -1;
    int prev;
    bit ramp_ok = 1'b1;
    set_cfg(4, 8, 0, 1, 1, 255, 2);
    bit_valid = 1'b1; bit_data = 1'b1;
    pulse_start();
    vec_cnt++;
    if (busy !== 1'b1) begin err_cnt++; $display("FAIL basic_busy_k1: got %b want 1", busy); end
    prev = int'(chan_level);
    for (int t = 0; t < 60; t++) begin
      tick();
      if (ui_strobe) begin strobes++; t_last = t; end
      if (done) begin dones++; if (t_done < 0) t_done = t; end
      if (chan_level == 10'd2 && t_lvl2 < 0) t_lvl2 = t;
      if (chan_out && t_out < 0) t_out = t;
      if (int'(chan_level) != prev && int'(chan_level) != prev + 1) ramp_ok = 1'b0;
      prev = int'(chan_level);
    end
    vec_cnt++;
    if (strobes != 8) begin err_cnt++; $display("FAIL basic_strobes: got %0d want 8", strobes); end
    vec_cnt++;
    if (chan_level !== 10'd32) begin err_cnt++; $display("FAIL basic_level: got %0d want 32", chan_level); end
    vec_cnt++;
    if (!ramp_ok) begin err_cnt++; $display("FAIL basic_ramp: got non-unit step want +1 steps"); end
    vec_cnt++;
    if (t_lvl2 < 0 || t_out != t_lvl2 + 1) begin
      err_cnt++; $display("FAIL basic_slice_lag: got out@%0d want %0d", t_out, t_lvl2 + 1);
    end
    vec_cnt++;
    if (t_done < 0 || t_done != t_last + 1 || dones != 1) begin
      err_cnt++; $display("FAIL basic_done: got done@%0d x%0d want @%0d x1", t_done, dones, t_last + 1);
    end
    vec_cnt++;
    if ({busy, underrun} !== 2'b00) begin
      err_cnt++; $display("FAIL basic_end_flags: got busy/underrun %b want 00", {busy, underrun});
    end
  endtask

  task automatic test_saturation();
    logic [9:0] exp_lvl [10];
    int n = 0;
    exp_lvl = '{10'd3, 10'd6, 10'd9, 10'd10, 10'd10, 10'd6, 10'd2, 10'd0, 10'd0, 10'd0};
    set_cfg(5, 2, 0, 3, 4, 10, 5);
    bit_valid = 1'b1; bit_data = 1'b1;
    pulse_start();
    while (!bit_ready && n < 20) begin tick(); n++; end
    vec_cnt++;
    if (chan_level !== 10'd0) begin err_cnt++; $display("FAIL sat_clear: got %0d want 0", chan_level); end
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) bit_data = 1'b0;
      vec_cnt++;
      if (chan_level !== exp_lvl[i]) begin
        err_cnt++; $display("FAIL sat_level[%0d]: got %0d want %0d", i, chan_level, exp_lvl[i]);
      end
    end
    vec_cnt++;
    if (done !== 1'b1) begin err_cnt++; $display("FAIL sat_done: got %b want 1", done); end
    tick();
  endtask

  task automatic test_underrun();
    int strobes = 0, n = 0;
    bit saw_done = 1'b0, ready_at_gap = 1'b0;
    set_cfg(3, 5, 0, 1, 1, 255, 200);
    bit_valid = 1'b0; bit_data = 1'b1;
    pulse_start();
    while (!bit_ready && n < 20) begin tick(); n++; end
    repeat (3) tick();
    vec_cnt++;
    if ({bit_ready, underrun} !== 2'b10) begin
      err_cnt++; $display("FAIL urun_first_wait: got ready/urun %b want 10", {bit_ready, underrun});
    end
    bit_valid = 1'b1;
    for (int t = 0; t < 40 && !saw_done; t++) begin
      tick();
      bit_valid = 1'b1;
      if (done) saw_done = 1'b1;
      if (ui_strobe) begin
        strobes++;
        if (strobes == 2) begin ready_at_gap = bit_ready; bit_valid = 1'b0; end
      end
    end
    vec_cnt++;
    if (!saw_done || strobes != 5) begin
      err_cnt++; $display("FAIL urun_uis: got %0d strobes done=%b want 5 done=1", strobes, saw_done);
    end
    vec_cnt++;
    if (chan_level !== 10'd15) begin err_cnt++; $display("FAIL urun_repeat: got %0d want 15", chan_level); end
    vec_cnt++;
    if (!ready_at_gap) begin err_cnt++; $display("FAIL urun_ready_gap: got 0 want 1"); end
    tick();
    tick();
    vec_cnt++;
    if (underrun !== 1'b1) begin err_cnt++; $display("FAIL urun_sticky: got %b want 1", underrun); end
  endtask

  task automatic test_abort();
    int n = 0;
    bit bad = 1'b0;
    set_cfg(4, 8, 0, 1, 1, 255, 2);
    bit_valid = 1'b1; bit_data = 1'b1;
    pulse_start();
    vec_cnt++;
    if (underrun !== 1'b0) begin err_cnt++; $display("FAIL abort_urun_clear: got %b want 0", underrun); end
    while (!ui_strobe && n < 20) begin tick(); n++; end
    vec_cnt++;
    if ({bit_ready, chan_level} !== {1'b1, 10'd3}) begin
      err_cnt++; $display("FAIL abort_pre: got ready=%b lvl=%0d want 1/3", bit_ready, chan_level);
    end
    abort = 1'b1;
    #1;
    vec_cnt++;
    if (bit_ready !== 1'b0) begin err_cnt++; $display("FAIL abort_ready: got %b want 0", bit_ready); end
    tick();
    abort = 1'b0;
    vec_cnt++;
    if ({busy, done, chan_level} !== {2'b00, 10'd3}) begin
      err_cnt++; $display("FAIL abort_idle: got busy=%b done=%b lvl=%0d want 0/0/3", busy, done, chan_level);
    end
    repeat (5) begin
      tick();
      if (done || busy || chan_level != 10'd3) bad = 1'b1;
    end
    vec_cnt++;
    if (bad) begin err_cnt++; $display("FAIL abort_hold: got activity after abort want none"); end
    set_cfg(2, 3, 0, 2, 1, 255, 2);
    pulse_start();
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    vec_cnt++;
    if ({done, chan_level} !== {1'b1, 10'd12}) begin
      err_cnt++; $display("FAIL abort_rerun: got done=%b lvl=%0d want 1/12", done, chan_level);
    end
    tick();
  endtask

  task automatic test_nbits_zero();
    bit rdy = 1'b0;
    set_cfg(4, 0, 0, 1, 1, 255, 2);
    start = 1'b1;
    #1;
    rdy = bit_ready;
    tick();
    start = 1'b0;
    rdy = rdy | bit_ready;
    vec_cnt++;
    if ({done, busy, chan_level} !== {2'b11, 10'd12}) begin
      err_cnt++; $display("FAIL nb0_k1: got done=%b busy=%b lvl=%0d want 1/1/12", done, busy, chan_level);
    end
    tick();
    rdy = rdy | bit_ready;
    vec_cnt++;
    if ({done, busy, chan_level, rdy} !== {2'b00, 10'd12, 1'b0}) begin
      err_cnt++; $display("FAIL nb0_k2: got done=%b busy=%b lvl=%0d rdy=%b want 0/0/12/0", done, busy, chan_level, rdy);
    end
  endtask

  task automatic test_settle_period();
    int n = 0, strobes = 0;
    set_cfg(0, 2, 3, 1, 1, 255, 2);
    bit_valid = 1'b1; bit_data = 1'b1;
    pulse_start();
    cfg_up_step = 4'd7;
    cfg_period  = 8'd9;
    while (!bit_ready && n < 20) begin tick(); n++; end
    vec_cnt++;
    if (n != 4) begin err_cnt++; $display("FAIL settle_len: got %0d want 4", n); end
    n = 0;
    while (!done && n < 40) begin tick(); n++; if (ui_strobe) strobes++; end
    vec_cnt++;
    if ({done, chan_level} !== {1'b1, 10'd4} || strobes != 2) begin
      err_cnt++; $display("FAIL period_min: got done=%b lvl=%0d strobes=%0d want 1/4/2", done, chan_level, strobes);
    end
    tick();
  endtask

  task automatic test_slicer();
    int rise_lvl = -1, fall_lvl = -1, n = 0, exp_rise, exp_fall;
    int prev_lvl;
    logic prev_out = 1'b0;
`ifdef CHAN_FADE_HYST_EN
    exp_rise = 28; exp_fall = 11;
`else
    exp_rise = 20; exp_fall = 19;
`endif
    set_cfg(40, 2, 0, 1, 1, 255, 20);
    bit_valid = 1'b1; bit_data = 1'b1;
    pulse_start();
    prev_lvl = int'(chan_level);
    while (!done && n < 150) begin
      tick();
      n++;
      if (chan_level >= 10'd30) bit_data = 1'b0;
      if (chan_out && !prev_out && rise_lvl < 0) rise_lvl = prev_lvl;
      if (!chan_out && prev_out && rise_lvl >= 0 && fall_lvl < 0) fall_lvl = prev_lvl;
      prev_out = chan_out;
      prev_lvl = int'(chan_level);
    end
    vec_cnt++;
    if (rise_lvl != exp_rise) begin err_cnt++; $display("FAIL slicer_rise: got %0d want %0d", rise_lvl, exp_rise); end
    vec_cnt++;
    if (fall_lvl != exp_fall) begin err_cnt++; $display("FAIL slicer_fall: got %0d want %0d", fall_lvl, exp_fall); end
    tick();
  endtask

  task automatic test_async_reset();
    int n = 0;
    bit bad = 1'b0;
    set_cfg(4, 8, 0, 1, 1, 255, 2);
    bit_valid = 1'b1; bit_data = 1'b1;
    pulse_start();
    while (chan_level < 10'd6 && n < 30) begin tick(); n++; end
    #2;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({busy, done, ui_strobe, chan_out, underrun, bit_ready, chan_level} !== 16'd0) begin
      err_cnt++; $display("FAIL async_rst: got flags=%b lvl=%0d want 0/0",
        {busy, done, ui_strobe, chan_out, underrun, bit_ready}, chan_level);
    end
    @(negedge faster_clk);
    rst_n = 1'b1;
    repeat (5) begin tick(); if (done || busy) bad = 1'b1; end
    vec_cnt++;
    if (bad) begin err_cnt++; $display("FAIL async_no_done: got done/busy after reset want none"); end
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; bit_valid = 1'b0; bit_data = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_basic();
    test_saturation();
    test_underrun();
    test_abort();
    test_nbits_zero();
    test_settle_period();
    test_slicer();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/chan_fade_ctrl.md
# chan_fade_ctrl

Run controller for the channel fading model. It sequences one channel-emulation run: clears the channel integrator, waits a settle time, pulls stimulus bits over a ready/valid handshake, and holds each bit for one unit interval (UI) of `faster_clk` cycles. It drives a saturating up/down fading integrator and slices the integrator level into a recovered bit for the RX front end. It sits between the TX stimulus source and the RX datapath in the channel test environment.

## Interface
- `ACC_W`, 10, integrator/level width
- `PERIOD_W`, 8, width of UI length and settle counters
- `CNT_W`, 16, width of bits-per-run counter
- `HYST`, 8, slicer hysteresis half-width (used only with `CHAN_FADE_HYST_EN`)

Reset `rst_n` is asynchronous, active-low. Clock is `faster_clk`.

- `faster_clk`  in  1  model clock, all logic on rising edge
- `rst_n`  in  1  async active-low reset
- `start`  in  1  single-cycle run request, honoured only in IDLE
- `abort`  in  1  terminate run, any non-IDLE state
- `cfg_period`  in  PERIOD_W  cycles per UI; values 0/1 treated as 2
- `cfg_nbits`  in  CNT_W  bits per run
- `cfg_settle`  in  PERIOD_W  settle cycles after clear
- `cfg_up_step`  in  4  integrator increment while bit=1
- `cfg_dn_step`  in  4  integrator decrement while bit=0
- `cfg_ceil`  in  ACC_W  saturation ceiling
- `cfg_thresh`  in  ACC_W  slicer threshold
- `bit_valid`  in  1  stimulus bit available
- `bit_data`  in  1  stimulus bit
- `bit_ready`  out  1  controller accepts a bit this cycle
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse at normal run completion
- `ui_strobe`  out  1  high in the last cycle of each UI
- `chan_level`  out  ACC_W  integrator value
- `chan_out`  out  1  sliced level
- `underrun`  out  1  sticky: no valid bit at a UI boundary

## Operation
- All `cfg_*` inputs are latched on an accepted `start`. Later changes have no effect until the next run.
- FSM states: IDLE, CLEAR, SETTLE, LOAD, RUN, DONE.
- IDLE to CLEAR on `start` when `cfg_nbits`!=0. IDLE to DONE when `cfg_nbits`==0. `start` also clears `underrun`.
- CLEAR (1 cycle): `chan_level`<=0 and `chan_out`<=0. Go to SETTLE, or to LOAD if settle==0.
- SETTLE: count `cfg_settle` cycles, then go to LOAD.
- LOAD: `bit_ready`=1. It stays in LOAD until `bit_valid`. The first bit never flags underrun. On handshake, capture `bit_data`, load UI counter = period-1, go to RUN.
- RUN: every cycle the integrator applies the current bit.
  - Bit=1: level = min(level+up_step, ceil). The sum is computed at ACC_W+1 bits.
  - Bit=0: level = max(level-dn_step, 0). No wrap.
- RUN, when UI counter==0:
  - `ui_strobe`=1 and bits_left decrements.
  - If bits_left reaches 0, go to DONE.
  - Otherwise `bit_ready`=1 in that cycle. If `bit_valid`, take the new bit; else set `underrun` and repeat the previous bit.
  - The UI counter reloads either way.
- DONE (1 cycle): `done`=1, then IDLE. `chan_level` holds its value in IDLE.
- `abort` in any non-IDLE state forces IDLE on the next edge. Abort wins over every other transition and over a simultaneous handshake. No `done` pulse. `bit_ready` is forced 0 in the abort cycle. Level is held.
- Slicer: `chan_out` <= (`chan_level` >= thresh), registered from the current level.

## Timing
- Reset: state IDLE. All outputs are 0, including `chan_level`, `underrun` and `done`. Counters are 0.
- `start` is sampled at edge k. `busy` is high from cycle k+1.
- RUN length is exactly nbits×period cycles, independent of underruns.
- `bit_ready` is combinational from state and counter. It is never high in IDLE, CLEAR, SETTLE or DONE.
- `chan_out` lags `chan_level` by one cycle.
- `done` is high at cycle (last `ui_strobe`)+1. `busy` falls the cycle after `done`.
- Async reset mid-run returns the block to IDLE immediately. It does not produce a `done` pulse.

## Configuration
- `CHAN_FADE_HYST_EN`, when defined: the slicer sets `chan_out` when level >= thresh+HYST and clears it when level < thresh-HYST. Otherwise `chan_out` holds. The thresh±HYST values saturate to 0 and to 2^ACC_W-1.
- When not defined: single-threshold slicer as described in Operation. The `HYST` parameter is unused.

## Structure
- Package `chan_ctrl_pkg` contains:
  - the FSM state enum `chan_ctrl_state_e`;
  - default width constants for `ACC_W`, `PERIOD_W` and `CNT_W`;
  - the minimum-period constant (2).
- Sub-module `chan_fade_integrator` holds the saturating up/down accumulator. Its inputs are clear, enable, bit, steps and ceil; its output is level. The FSM and counters stay in `chan_fade_ctrl`.

## Test plan
- Basic run. Setup: period=4, nbits=8, up=dn=1, ceil=255, thresh=2, settle=0, all ones, valid always high. Expected: level ramps 1..32; `chan_out` rises one cycle after level=2; 8 `ui_strobe`s; `done` one cycle after the last strobe.
- Saturation. Setup: ceil=10, up=3, ones. Expected: level 3,6,9,10,10. Then a zero bit with dn=4 gives 6,2,0,0.
- Underrun. Setup: nbits=5, `bit_valid` low at the 2nd UI boundary. Expected: `underrun`=1 (sticky until next `start`), previous bit repeated, exactly 5 UIs, `done` asserted.
- Abort mid-RUN. Expected: IDLE on the next edge, `busy`=0, no `done`, `chan_level` held. A following `start` runs normally.
- nbits=0. Expected: `done` pulse at k+1, `bit_ready` never high, level unchanged.
- Hysteresis with the macro defined. Setup: thresh=20, HYST=8, level swept 0..40..0. Expected: `chan_out` rises at level 28 and falls at level 11. Also apply async reset mid-run and check all outputs are 0.
